// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: FSM/probe encoding, parity modes
// and bit-time helper.
package uart_pkg;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StStart  = 4'd1,
        StData   = 4'd2,
        StParity = 4'd3,
        StStop   = 4'd4,
        StBreak  = 4'd5
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    function automatic int unsigned calc_bit_time(input int unsigned sys_clk_hz,
                                                  input int unsigned baud);
        return sys_clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words between the host handshake and the TX shifter.
// DEPTH must be a power of two so the pointers wrap for free.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_level == FULL_LEVEL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Configurable-format UART transmitter with a valid/ready input FIFO.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLOCK_FREQUENCY = 50000000,
    parameter int unsigned BAUD_RATE           = 115200,
    parameter int unsigned DATA_BITS           = 8,
    parameter int unsigned PARITY              = 0,
    parameter int unsigned STOP_BITS           = 1,
    parameter int unsigned FIFO_DEPTH          = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          valid,
    output logic                          ready,
`ifdef UART_TX_BREAK_EN
    input  logic                          break_req,
`endif
    output logic                          TX,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [3:0]                    probe
);

    localparam int unsigned BIT_TIME = calc_bit_time(SYS_CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned TW       = $clog2(BIT_TIME);
    localparam int unsigned IW       = 4;

    localparam logic [TW-1:0] TIMER_MAX = TW'(BIT_TIME - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
`ifdef UART_TX_BREAK_EN
    localparam logic [IW-1:0] BRK_LAST  = IW'(DATA_BITS + 2);
    localparam logic [IW-1:0] BRK_DONE  = IW'(DATA_BITS + 3);
`endif

    uart_state_e          r_state;
    uart_state_e          w_state_next;
    logic [TW-1:0]        r_timer;
    logic [TW-1:0]        w_timer_next;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_parity;
    logic                 w_parity_next;
    logic                 r_tx;
    logic                 w_tx_next;
`ifdef UART_TX_BREAK_EN
    logic                 r_hold;
    logic                 w_hold_next;
`endif

    logic                 w_tick;
    logic                 w_load;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_par_bit;
    logic [DATA_BITS-1:0] w_fifo_data;

    assign ready  = !w_full;
    assign w_push = valid && !w_full;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (data),
        .i_pop   (w_load),
        .o_data  (w_fifo_data),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_tick    = (r_timer == TIMER_MAX);
    assign w_par_bit = (PARITY == PARITY_ODD) ? ~(^w_fifo_data) : (^w_fifo_data);

    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = w_tick ? '0 : r_timer + 1'b1;
        w_idx_next    = r_idx;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_load        = 1'b0;
        w_tx_next     = 1'b1;
`ifdef UART_TX_BREAK_EN
        w_hold_next   = r_hold;
`endif
        case (r_state)
            StIdle: begin
                w_timer_next = '0;
`ifdef UART_TX_BREAK_EN
                // Post-break guard: line stays high one full bit time.
                if (r_hold && !w_tick) begin
                    w_timer_next = r_timer + 1'b1;
                end else begin
                    w_hold_next = 1'b0;
                    if (break_req) begin
                        w_state_next = StBreak;
                        w_idx_next   = '0;
                    end else begin
                        w_load = !w_empty;
                    end
                end
`else
                w_load = !w_empty;
`endif
            end
            StStart: begin
                if (w_tick) begin
                    w_state_next = StData;
                    w_idx_next   = '0;
                end
            end
            StData: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_idx == LAST_DATA) begin
                        w_idx_next   = '0;
                        w_state_next = (PARITY != PARITY_NONE) ? StParity : StStop;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            StParity: begin
                if (w_tick) begin
                    w_state_next = StStop;
                    w_idx_next   = '0;
                end
            end
            StStop: begin
                if (w_tick) begin
                    if (r_idx == LAST_STOP) begin
                        w_idx_next   = '0;
                        w_state_next = StIdle;
`ifdef UART_TX_BREAK_EN
                        // A pending break wins over the next queued frame.
                        w_load = !w_empty && !break_req;
`else
                        w_load = !w_empty;
`endif
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
                if (w_tick && (r_idx != BRK_DONE)) begin
                    w_idx_next = r_idx + 1'b1;
                end
                if (!break_req && ((r_idx == BRK_DONE) || (w_tick && (r_idx == BRK_LAST)))) begin
                    w_state_next = StIdle;
                    w_idx_next   = '0;
                    w_timer_next = '0;
                    w_hold_next  = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = StIdle;
                w_timer_next = '0;
                w_idx_next   = '0;
            end
        endcase

        if (w_load) begin
            w_state_next  = StStart;
            w_timer_next  = '0;
            w_idx_next    = '0;
            w_shift_next  = w_fifo_data;
            w_parity_next = w_par_bit;
        end

        case (w_state_next)
            StStart:  w_tx_next = 1'b0;
            StData:   w_tx_next = w_shift_next[0];
            StParity: w_tx_next = w_parity_next;
`ifdef UART_TX_BREAK_EN
            StBreak:  w_tx_next = 1'b0;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_timer  <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
`ifdef UART_TX_BREAK_EN
            r_hold   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_timer  <= w_timer_next;
            r_idx    <= w_idx_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
`ifdef UART_TX_BREAK_EN
            r_hold   <= w_hold_next;
`endif
        end
    end

    assign TX    = r_tx;
    assign busy  = (r_state != StIdle) || !w_empty;
    assign probe = r_state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three instances (8N1, 7E2, 7O2) at BIT_TIME=10, table-driven
// frame vectors plus burst, reset-abort and optional break sequences.
module tb_uart_tx_frame;

    localparam int unsigned SYS  = 1000000;
    localparam int unsigned BAUD = 100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [6:0] d2;
    logic       v0, v1, v2;
    logic       w_ready [3];
    logic       w_tx    [3];
    logic       w_busy  [3];
    logic [2:0] w_level [3];
    logic [3:0] w_probe [3];
`ifdef UART_TX_BREAK_EN
    logic       brk0;
`endif

    uart_tx_frame #(
        .SYS_CLOCK_FREQUENCY (SYS), .BAUD_RATE (BAUD), .DATA_BITS (8),
        .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) u_8n1 (
        .clk (clk), .rst_n (rst_n), .data (d0), .valid (v0), .ready (w_ready[0]),
`ifdef UART_TX_BREAK_EN
        .break_req (brk0),
`endif
        .TX (w_tx[0]), .busy (w_busy[0]), .fifo_level (w_level[0]), .probe (w_probe[0])
    );

    uart_tx_frame #(
        .SYS_CLOCK_FREQUENCY (SYS), .BAUD_RATE (BAUD), .DATA_BITS (7),
        .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (4)
    ) u_7e2 (
        .clk (clk), .rst_n (rst_n), .data (d1), .valid (v1), .ready (w_ready[1]),
`ifdef UART_TX_BREAK_EN
        .break_req (1'b0),
`endif
        .TX (w_tx[1]), .busy (w_busy[1]), .fifo_level (w_level[1]), .probe (w_probe[1])
    );

    uart_tx_frame #(
        .SYS_CLOCK_FREQUENCY (SYS), .BAUD_RATE (BAUD), .DATA_BITS (7),
        .PARITY (1), .STOP_BITS (2), .FIFO_DEPTH (4)
    ) u_7o2 (
        .clk (clk), .rst_n (rst_n), .data (d2), .valid (v2), .ready (w_ready[2]),
`ifdef UART_TX_BREAK_EN
        .break_req (1'b0),
`endif
        .TX (w_tx[2]), .busy (w_busy[2]), .fifo_level (w_level[2]), .probe (w_probe[2])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int unsigned d, input logic [7:0] v, input logic vld);
        case (d)
            0:       begin d0 = v;      v0 = vld; end
            1:       begin d1 = v[6:0]; v1 = vld; end
            default: begin d2 = v[6:0]; v2 = vld; end
        endcase
    endtask

    // Independent receiver on the 8N1 line: samples mid-bit, logs bytes and start cycles.
    int         cyc = 0;
    int         mon_cnt = 0;
    int         mon_err = 0;
    logic       mon_act = 1'b0;
    logic [7:0] mon_sh = '0;
    logic [7:0] mon_bytes [$];
    int         mon_starts [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_act <= 1'b0;
            mon_cnt <= 0;
        end else if (!mon_act) begin
            if (w_tx[0] == 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
                mon_starts.push_back(cyc);
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt == 5 && w_tx[0] !== 1'b0) mon_err <= mon_err + 1;
            if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5)
                mon_sh <= {w_tx[0], mon_sh[7:1]};
            if (mon_cnt == 95) begin
                if (w_tx[0] !== 1'b1) mon_err <= mon_err + 1;
                mon_bytes.push_back(mon_sh);
            end
            if (mon_cnt == 99) mon_act <= 1'b0;
        end
    end

    typedef struct {
        int unsigned dut;
        logic [7:0]  data;
        int unsigned nbits;
        logic [11:0] frame;   // frame[k] = line level during bit k (start first)
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input int i, input vec_t v);
        int d;
        d = int'(v.dut);
        @(negedge clk);
        set_in(v.dut, v.data, 1'b1);
        chk($sformatf("v%0d_ready", i), w_ready[d], 1);
        @(negedge clk);
        set_in(v.dut, v.data, 1'b0);
        chk($sformatf("v%0d_level_after_push", i), w_level[d], 1);
        chk($sformatf("v%0d_idle_tx", i), w_tx[d], 1);
        @(negedge clk);
        for (int t = 0; t <= int'(v.nbits) * 10; t++) begin
            if (t == 0) chk($sformatf("v%0d_probe_start", i), w_probe[d], 1);
            if (t < int'(v.nbits) * 10) begin
                if ((t % 10) == 0 || (t % 10) == 9)
                    chk($sformatf("v%0d_bit%0d_t%0d", i, t / 10, t), w_tx[d], v.frame[t / 10]);
                if (t == int'(v.nbits) * 10 - 1)
                    chk($sformatf("v%0d_busy_last", i), w_busy[d], 1);
            end else begin
                chk($sformatf("v%0d_busy_end", i), w_busy[d], 0);
                chk($sformatf("v%0d_probe_end", i), w_probe[d], 0);
            end
            if (t < int'(v.nbits) * 10) @(negedge clk);
        end
    endtask

    task automatic wait_idle0();
        int n;
        n = 0;
        while (w_busy[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle0", w_busy[0], 0);
    endtask

    logic [7:0] burst [6];
    int         base, sbase, ebase, n;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'h48, 10, 12'h290};
        vecs[1] = '{0, 8'hA5, 10, 12'h34A};
        vecs[2] = '{0, 8'h00, 10, 12'h200};
        vecs[3] = '{0, 8'hFF, 10, 12'h3FE};
        vecs[4] = '{1, 8'h35, 11, 12'h66A};
        vecs[5] = '{2, 8'h35, 11, 12'h76A};
        vecs[6] = '{1, 8'h7F, 11, 12'h7FE};
        vecs[7] = '{2, 8'h00, 11, 12'h700};
        vecs[8] = '{1, 8'h01, 11, 12'h702};
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;

        rst_n = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk0 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_tx%0d", d), w_tx[d], 1);
            chk($sformatf("rst_busy%0d", d), w_busy[d], 0);
            chk($sformatf("rst_ready%0d", d), w_ready[d], 1);
            chk($sformatf("rst_level%0d", d), w_level[d], 0);
            chk($sformatf("rst_probe%0d", d), w_probe[d], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Burst: five pushes fill the FIFO, junk offers while full must be dropped.
        wait_idle0();
        base  = mon_bytes.size();
        sbase = mon_starts.size();
        ebase = mon_err;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            set_in(0, burst[i], 1'b1);
            chk($sformatf("burst_ready%0d", i), w_ready[0], 1);
            @(negedge clk);
        end
        chk("burst_full_level", w_level[0], 4);
        chk("burst_full_ready", w_ready[0], 0);
        for (int i = 0; i < 10; i++) begin
            set_in(0, 8'hE0 + 8'(i), 1'b1);
            @(negedge clk);
            chk($sformatf("burst_blocked%0d", i), w_ready[0], 0);
        end
        set_in(0, 8'h00, 1'b0);
        n = 0;
        while (!w_ready[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("burst_ready_back", w_ready[0], 1);
        chk("burst_level_after_pop", w_level[0], 3);
        set_in(0, burst[5], 1'b1);
        @(negedge clk);
        set_in(0, 8'h00, 1'b0);
        n = 0;
        while ((mon_bytes.size() - base) < 6 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("burst_count", mon_bytes.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < mon_bytes.size())
                chk($sformatf("burst_byte%0d", i), mon_bytes[base + i], burst[i]);
        end
        for (int i = 1; i < 6; i++) begin
            if (sbase + i < mon_starts.size())
                chk($sformatf("burst_gap%0d", i),
                    mon_starts[sbase + i] - mon_starts[sbase + i - 1], 100);
        end
        chk("burst_frame_errs", mon_err - ebase, 0);
        wait_idle0();
        repeat (3) @(negedge clk);
        chk("burst_no_extra", mon_bytes.size() - base, 6);

        // Reset at cycle 35 of a frame, with two words still queued.
        @(negedge clk);
        set_in(0, 8'h5A, 1'b1); @(negedge clk);
        set_in(0, 8'h0F, 1'b1); @(negedge clk);
        set_in(0, 8'hF0, 1'b1); @(negedge clk);
        set_in(0, 8'h00, 1'b0);
        repeat (34) @(negedge clk);
        chk("pre_rst_tx", w_tx[0], 0);
        chk("pre_rst_level", w_level[0], 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", w_tx[0], 1);
        chk("async_rst_busy", w_busy[0], 0);
        chk("async_rst_level", w_level[0], 0);
        chk("async_rst_probe", w_probe[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = mon_bytes.size();
        @(negedge clk);
        set_in(0, 8'hC3, 1'b1); @(negedge clk);
        set_in(0, 8'h00, 1'b0);
        wait_idle0();
        repeat (3) @(negedge clk);
        chk("post_rst_count", mon_bytes.size() - base, 1);
        if (base < mon_bytes.size()) chk("post_rst_byte", mon_bytes[base], 8'hC3);

`ifdef UART_TX_BREAK_EN
        // Break for 50 cycles: line low for 110, high for 10, then the queued frame.
        @(negedge clk);
        brk0 = 1'b1;
        @(negedge clk);
        for (int t = 0; t <= 120; t++) begin
            if (t == 0) begin
                chk("brk_probe", w_probe[0], 5);
                chk("brk_busy", w_busy[0], 1);
                set_in(0, 8'h81, 1'b1);
            end
            if (t == 1) set_in(0, 8'h00, 1'b0);
            if (t == 50) brk0 = 1'b0;
            if (t == 0 || t == 109) chk($sformatf("brk_low_t%0d", t), w_tx[0], 0);
            if (t == 110 || t == 119) chk($sformatf("brk_high_t%0d", t), w_tx[0], 1);
            if (t == 120) begin
                chk("brk_next_start_tx", w_tx[0], 0);
                chk("brk_next_start_probe", w_probe[0], 1);
            end
            if (t < 120) @(negedge clk);
        end
        wait_idle0();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, next generation of the single-format 8N1 transmitter. Frame format is configurable: data width, parity mode and stop-bit count. A valid/ready handshake replaces the rdy pulse-and-release protocol. A small FIFO absorbs bursts, so back-to-back frames go out with no idle gap. It sits between a host-side byte producer and the serial TX pin.

Parameters:
SYS_CLOCK_FREQUENCY, 50000000, system clock in Hz
BAUD_RATE, 115200, line rate in bit/s; BIT_TIME = SYS_CLOCK_FREQUENCY/BAUD_RATE cycles (integer divide, must be >= 2)
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, entries, power of two >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data  in  DATA_BITS  word to send
valid  in  1  data is offered this cycle
ready  out  1  FIFO can accept; transfer occurs when valid && ready at posedge clk
TX  out  1  serial line, idle high
busy  out  1  FIFO non-empty or frame in progress
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
probe  out  4  current FSM state encoding, for debug

Behaviour:
- Reset (rst_n low, async): TX=1, busy=0, ready=1, fifo_level=0, FSM=IDLE, bit timer=0, bit index=0. If reset hits mid-frame, the frame is aborted and TX returns high immediately. FIFO contents are discarded.
- ready = (fifo_level != FIFO_DEPTH), driven from registered state, no combinational path from valid. valid while !ready is ignored; the word is not stored.
- FSM states: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5 (optional feature only). Every other encoding returns to IDLE on the next clock.
- IDLE: if FIFO non-empty, pop the head into the shift register, compute parity, go to START, and drive TX=0 on the same edge.
- Latency: word accepted at edge N into an empty FIFO while IDLE gives FSM=START and TX=0 at edge N+1.
- Each bit holds TX for exactly BIT_TIME cycles. The timer counts 0..BIT_TIME-1 and advances on terminal count.
- DATA: LSB first, DATA_BITS bits. Then go to PARITY if PARITY != 0, else STOP.
- Parity bit: odd makes the total ones in data+parity odd; even makes it even.
- STOP: TX=1 for STOP_BITS*BIT_TIME cycles. At the end, if the FIFO is non-empty, pop and enter START directly with no idle cycle; else go to IDLE.
- Frame length: (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BIT_TIME cycles.
- Simultaneous push and pop in one cycle: level unchanged. Push accepted when full-with-pop-this-cycle is NOT allowed, because ready is registered.
- Read/write pointers wrap modulo FIFO_DEPTH.
- busy = (FSM != IDLE) || (fifo_level != 0).

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input port break_req (1 bit).
  - In IDLE, break_req=1 takes priority over a FIFO pop. The FSM enters BREAK and holds TX=0 while break_req is high. The BREAK state lasts at least (DATA_BITS+3)*BIT_TIME cycles.
  - It then returns to IDLE with TX=1 for one BIT_TIME minimum before the next start bit.
  - break_req during a frame is deferred until the frame completes. busy=1 in BREAK.
- Undefined: no port, no BREAK state, encoding 5 unused.

Decomposition:
- Shared package uart_pkg:
  - FSM state constants with the probe encoding.
  - Parity mode constants PARITY_NONE/ODD/EVEN.
  - Function computing BIT_TIME.
- Sub-module uart_tx_fifo: parametrised synchronous FIFO (width DATA_BITS, depth FIFO_DEPTH) with push, pop, level, full and empty.
- Top level holds the FSM, bit timer and shift register.

Test Plan:
- SYS=1000000, BAUD=100000 (BIT_TIME=10), 8N1, send 0x48 → TX low at accept+1, then bits 0,0,0,1,0,0,1,0, stop 1. Each bit lasts 10 cycles, frame 100 cycles, busy drops after the stop bit.
- Same clocking, DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x35 (four ones) → parity bit 0, two stop bits, frame 110 cycles. Repeat with PARITY=1 → parity bit 1.
- FIFO_DEPTH=4, push 5 words on consecutive cycles → ready deasserts once fifo_level reaches 4. The 5th word is taken only after the first pop. All frames go out back-to-back with no high gap beyond the stop bits.
- Assert rst_n=0 at cycle 35 of a frame → TX=1, busy=0, fifo_level=0 asynchronously. After release, a new word transmits normally.
- valid held high with changing data while ready=0 → no extra words transmitted; output sequence equals accepted words only.
- With UART_TX_BREAK_EN, break_req high for 50 cycles in IDLE (8-bit, BIT_TIME=10) → TX low for 110 cycles, then high for at least 10 cycles before a queued frame starts.
